// File: rtl/jt900h_ramarb.sv
// jt900h main RAM arbiter: one 16-bit byte-writable RAM port shared
// between the CPU and a second bus master (DMA / debug engine).

module jt900h_ramarb #(
   parameter int RDLAT    = 0,
   parameter bit CPU_PRIO = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cen,
   input  logic        cpu_req,
   input  logic [23:0] cpu_addr,
   input  logic [1:0]  cpu_we,
   input  logic [15:0] cpu_din,
   output logic [15:0] cpu_dout,
   output logic        cpu_ack,
   input  logic        dma_req,
   input  logic [23:0] dma_addr,
   input  logic [1:0]  dma_we,
   input  logic [15:0] dma_din,
   output logic [15:0] dma_dout,
   output logic        dma_ack,
   output logic [23:0] ram_addr,
   output logic [15:0] ram_din,
   output logic [1:0]  ram_we,
   input  logic [15:0] ram_dout,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      WAIT,
      DONE
   } state_t;

   localparam logic [1:0] CNT_LOAD = 2'(RDLAT > 0 ? RDLAT - 1 : 0);

   state_t      st;
   state_t      st_nx;
   logic [1:0]  cnt;
   logic [1:0]  cnt_nx;
   logic        gnt_dma;
   logic        gnt_dma_nx;
   logic        last_dma;
   logic        last_dma_nx;
   logic        pick_dma;
   logic        cap;
   logic [1:0]  we_q;
   logic [1:0]  we_nx;
   logic [23:0] addr_nx;
   logic [15:0] din_nx;
   logic [15:0] cdout_nx;
   logic [15:0] ddout_nx;
   logic        cack_nx;
   logic        dack_nx;
   logic        busy_nx;

   // The strobe is registered but masked so it never shows in a stalled cycle
   assign ram_we = we_q & {2{cen}};

   // DMA wins only if the CPU is idle, or round-robin says it is DMA's turn
   assign pick_dma = dma_req & (~cpu_req | (~CPU_PRIO & ~last_dma));

   always_comb begin
      st_nx       = st;
      cnt_nx      = cnt;
      gnt_dma_nx  = gnt_dma;
      last_dma_nx = last_dma;
      we_nx       = we_q;
      addr_nx     = ram_addr;
      din_nx      = ram_din;
      busy_nx     = busy;
      cap         = 1'b0;
      unique case (st)
         IDLE: begin
            if (cpu_req | dma_req) begin
               gnt_dma_nx  = pick_dma;
               last_dma_nx = pick_dma;
               addr_nx     = pick_dma ? dma_addr : cpu_addr;
               we_nx       = pick_dma ? dma_we   : cpu_we;
               din_nx      = pick_dma ? dma_din  : cpu_din;
               busy_nx     = 1'b1;
               st_nx       = ACCESS;
            end
         end
         ACCESS: begin
            we_nx = 2'b00;
            if (RDLAT == 0) begin
               cap   = 1'b1;
               st_nx = DONE;
            end else begin
               cnt_nx = CNT_LOAD;
               st_nx  = WAIT;
            end
         end
         WAIT: begin
            if (cnt == 2'd0) begin
               cap   = 1'b1;
               st_nx = DONE;
            end else begin
               cnt_nx = cnt - 2'd1;
            end
         end
         DONE: begin
            busy_nx = 1'b0;
            st_nx   = IDLE;
         end
         default: st_nx = IDLE;
      endcase
   end

   always_comb begin
      cack_nx  = 1'b0;
      dack_nx  = 1'b0;
      cdout_nx = cpu_dout;
      ddout_nx = dma_dout;
      if (cap) begin
         if (gnt_dma) begin
            ddout_nx = ram_dout;
            dack_nx  = 1'b1;
         end else begin
            cdout_nx = ram_dout;
            cack_nx  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st       <= IDLE;
         cnt      <= 2'd0;
         gnt_dma  <= 1'b0;
         last_dma <= 1'b1;
         we_q     <= 2'b00;
         ram_addr <= 24'd0;
         ram_din  <= 16'd0;
         cpu_dout <= 16'd0;
         dma_dout <= 16'd0;
         cpu_ack  <= 1'b0;
         dma_ack  <= 1'b0;
         busy     <= 1'b0;
      end else if (cen) begin
         st       <= st_nx;
         cnt      <= cnt_nx;
         gnt_dma  <= gnt_dma_nx;
         last_dma <= last_dma_nx;
         we_q     <= we_nx;
         ram_addr <= addr_nx;
         ram_din  <= din_nx;
         cpu_dout <= cdout_nx;
         dma_dout <= ddout_nx;
         cpu_ack  <= cack_nx;
         dma_ack  <= dack_nx;
         busy     <= busy_nx;
      end
   end

endmodule
